// File: rtl/input_cond_pkg.sv
// Shared definitions for the board-input front end.
//   rst_state_t : reset sequencer states (HOLD drives sys_rstn low, RUN releases it)
//   cnt_width() : counter width helper, $clog2 with a floor of 1 bit so that
//                 small parameter values never produce zero-width vectors.
package input_cond_pkg;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } rst_state_t;

  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One input channel: two-flop synchroniser followed by a stable-count debouncer.
//   clk   : system clock
//   rstn  : synchronous active-low reset
//   raw   : asynchronous raw pin level
//   level : debounced level (registered)
//   rise  : one-cycle pulse in the cycle level goes 0->1 (registered)
// Valid/ready note: this block has no handshake; level is always valid and rise
// is a single-cycle strobe that the consumer must sample every cycle.
module debounce_ch
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any cycle where s2 agrees with level clears the count, so a glitch
  // shorter than DEBOUNCE_CYCLES never reaches level.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (s2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = s2_q;
        rise_d  = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/input_conditioner.sv
// Board-input front end: synchronises and debounces every button and switch,
// produces one-cycle button press pulses and a stretched system reset.
//   clk       : system clock
//   rstn      : synchronous active-low reset
//   btn_raw   : raw button levels (active-high, asynchronous)
//   sw_raw    : raw switch levels (asynchronous)
//   btn_level : debounced button levels
//   btn_press : one-cycle pulse per debounced button 0->1 transition
//   sw_level  : debounced switch levels
//   sys_rstn  : stretched active-low system reset, decoded from the state register
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int NUM_BTN         = 4,
  parameter int NUM_SW          = 16,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RST_HOLD_CYCLES = 8,
  parameter int RST_BTN         = 0
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [NUM_SW-1:0]  sw_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_SW-1:0]  sw_level,
  output logic               sys_rstn
);

  localparam int HW = cnt_width(RST_HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);

  logic [NUM_SW-1:0] sw_rise_unused;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
      .clk   (clk),
      .rstn  (rstn),
      .raw   (btn_raw[i]),
      .level (btn_level[i]),
      .rise  (btn_press[i])
    );
  end

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
      .clk   (clk),
      .rstn  (rstn),
      .raw   (sw_raw[i]),
      .level (sw_level[i]),
      .rise  (sw_rise_unused[i])
    );
  end

  // An out-of-range RST_BTN disables the button-triggered reset entirely.
  logic rst_trig;
  if (RST_BTN < NUM_BTN) begin : g_rst_btn
    assign rst_trig = btn_press[RST_BTN];
  end else begin : g_no_rst_btn
    assign rst_trig = 1'b0;
  end

  rst_state_t    state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;

  // A press arriving on the last hold cycle still restarts the hold, so the
  // low time always covers a full RST_HOLD_CYCLES after the latest press.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    case (state_q)
      HOLD: begin
        if (rst_trig) begin
          hcnt_d = '0;
        end else if (hcnt_q == HOLD_LAST) begin
          state_d = RUN;
          hcnt_d  = '0;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      RUN: begin
        if (rst_trig) begin
          state_d = HOLD;
          hcnt_d  = '0;
        end
      end
      default: begin
        state_d = HOLD;
        hcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= HOLD;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
    end
  end

  assign sys_rstn = (state_q == RUN);

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

  localparam int NB  = 4;
  localparam int NS  = 16;
  localparam int D   = 4;
  localparam int H   = 8;
  localparam int RB  = 0;
  localparam int NCH = NB + NS;
  localparam int W   = 1 + NB + NB + NS;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rstn;
  logic [NB-1:0] btn_raw;
  logic [NS-1:0] sw_raw;
  logic [NB-1:0] btn_level, btn_press;
  logic [NS-1:0] sw_level;
  logic          sys_rstn;

  always #5 clk = ~clk;

  input_conditioner #(
    .NUM_BTN(NB), .NUM_SW(NS), .DEBOUNCE_CYCLES(D),
    .RST_HOLD_CYCLES(H), .RST_BTN(RB)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .btn_raw   (btn_raw),
    .sw_raw    (sw_raw),
    .btn_level (btn_level),
    .btn_press (btn_press),
    .sw_level  (sw_level),
    .sys_rstn  (sys_rstn)
  );

  // ---------------- reference model ----------------
  // Per channel: raw is seen by the debouncer two edges late. A level flips
  // when the last D observed samples all disagree with it. The system reset
  // is a count of remaining low cycles, reloaded on reset or reset-button press.
  logic [W-1:0] exp_q[$];
  bit  m_p1[NCH], m_p2[NCH], m_lvl[NCH], m_rise[NCH];
  bit  m_win[NCH][D];
  int  m_rem;

  always @(posedge clk) begin
    logic [NCH-1:0] raw_v;
    logic [W-1:0]   e;
    bit             press_prev, flip;
    raw_v = {sw_raw, btn_raw};
    if (!rstn) begin
      for (int c = 0; c < NCH; c++) begin
        m_p1[c] = 0; m_p2[c] = 0; m_lvl[c] = 0; m_rise[c] = 0;
        for (int k = 0; k < D; k++) m_win[c][k] = 0;
      end
      m_rem = H;
    end else begin
      press_prev = m_rise[RB];
      for (int c = 0; c < NCH; c++) begin
        for (int k = 0; k < D - 1; k++) m_win[c][k] = m_win[c][k+1];
        m_win[c][D-1] = m_p2[c];
        flip = 1;
        for (int k = 0; k < D; k++) if (m_win[c][k] == m_lvl[c]) flip = 0;
        m_rise[c] = 0;
        if (flip) begin
          m_lvl[c]  = !m_lvl[c];
          m_rise[c] = m_lvl[c];
        end
        m_p2[c] = m_p1[c];
        m_p1[c] = raw_v[c];
      end
      if (press_prev) m_rem = H;
      else if (m_rem > 0) m_rem = m_rem - 1;
    end
    e[W-1] = (m_rem == 0);
    for (int i = 0; i < NB; i++) begin
      e[NS + NB + i] = m_lvl[i];
      e[NS + i]      = m_rise[i];
    end
    for (int i = 0; i < NS; i++) e[i] = m_lvl[NB + i];
    exp_q.push_back(e);
  end

  // ---------------- scoreboard monitor ----------------
  int n_vec = 0;
  int n_err = 0;

  always @(negedge clk) begin
    logic [W-1:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {sys_rstn, btn_level, btn_press, sw_level};
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL outputs t=%0t act rst=%b lvl=%b prs=%b sw=%h exp rst=%b lvl=%b prs=%b sw=%h",
                 $time, a[W-1], a[NS+2*NB-1:NS+NB], a[NS+NB-1:NS], a[NS-1:0],
                 e[W-1], e[NS+2*NB-1:NS+NB], e[NS+NB-1:NS], e[NS-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int idx, input logic v);
    btn_raw[idx] = v;
  endtask

  initial begin
    rstn    = 1'b0;
    btn_raw = '0;
    sw_raw  = '0;

    // power-up
    tick(5);
    rstn = 1'b1;
    tick(12);

    // clean press on button 2
    set_btn(2, 1'b1); tick(20);
    set_btn(2, 1'b0); tick(10);

    // bouncing button 1
    for (int k = 0; k < 5; k++) begin
      set_btn(1, (k % 2 == 0) ? 1'b1 : 1'b0);
      tick(2);
    end
    tick(12);
    set_btn(1, 1'b0); tick(10);

    // switch pattern and short glitch
    sw_raw = 16'hA5C3; tick(8);
    sw_raw = 16'h0000; tick(3);
    sw_raw = 16'hA5C3; tick(10);

    // button-triggered reset, single press then a press during the hold
    set_btn(0, 1'b1); tick(8);
    set_btn(0, 1'b0); tick(16);
    set_btn(0, 1'b1); tick(4);
    set_btn(0, 1'b0); tick(4);
    set_btn(0, 1'b1); tick(12);
    set_btn(0, 1'b0); tick(20);

    // reset pulse mid-debounce while running
    set_btn(3, 1'b1); tick(4);
    rstn = 1'b0; tick(1);
    rstn = 1'b1; tick(14);
    set_btn(3, 1'b0); tick(10);

    // randomized traffic
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 29) == 0) begin
        rstn = 1'b0;
        tick($urandom_range(1, 3));
        rstn = 1'b1;
      end else begin
        if ($urandom_range(0, 1) == 1) btn_raw = NB'($urandom);
        if ($urandom_range(0, 1) == 1) sw_raw  = NS'($urandom);
        tick($urandom_range(1, 8));
      end
    end
    tick(3);

    if (n_vec < 1000) begin
      n_err++;
      $display("FAIL vector_count act=%0d req>=1000", n_vec);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Parametrised board-input front end between raw FPGA pins (buttons, switches, reset) and the CPU core. Every raw input is synchronised and debounced. Buttons also produce one-cycle press pulses. A stretched, sequenced system reset `sys_rstn` is generated and can be re-triggered by a designated button. The block replaces the hard-wired reset/tie-off stimulus used around `top`, making input behaviour identical in simulation and on the board.

## Interface
- `NUM_BTN`, 4: number of button channels.
- `NUM_SW`, 16: number of switch channels.
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles required before a debounced level changes; ≥2.
- `RST_HOLD_CYCLES`, 8: cycles `sys_rstn` stays low after a reset trigger; ≥1.
- `RST_BTN`, 0: index of the button that re-triggers system reset; a value ≥ `NUM_BTN` disables button reset.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `btn_raw`  in  NUM_BTN  asynchronous raw button levels, active-high.
- `sw_raw`  in  NUM_SW  asynchronous raw switch levels.
- `btn_level`  out  NUM_BTN  debounced button levels.
- `btn_press`  out  NUM_BTN  one-cycle pulse on each debounced 0→1 button transition.
- `sw_level`  out  NUM_SW  debounced switch levels.
- `sys_rstn`  out  1  stretched system reset for downstream logic, active-low.

## Operation
- **Per-channel path** (identical for every button and switch):
  - Two-flop synchroniser `s1 → s2`.
  - Debounce counter `cnt` of width `$clog2(DEBOUNCE_CYCLES)`.
  - Registered `level` and `rise`.
- **Each cycle:**
  - If `s2 == level`: `cnt ← 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `level ← s2`, `cnt ← 0`.
  - Else: `cnt ← cnt+1`.
  - `rise ← 1` only in the cycle `level` goes 0→1; otherwise `rise ← 0`.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles, as seen at `s2`, resets `cnt` and never reaches `level`.
- Falling transitions are debounced the same way but produce no pulse.
- `btn_press` is the `rise` of each button channel. The switch channels' `rise` is unused.
- **Reset sequencer FSM**, states `HOLD` and `RUN`, with counter `hcnt` of width `$clog2(RST_HOLD_CYCLES+1)`:
  - `HOLD`: `sys_rstn = 0`, `hcnt ← hcnt+1`. When `hcnt == RST_HOLD_CYCLES-1`, go to `RUN` and clear `hcnt`.
  - `RUN`: `sys_rstn = 1`. If `RST_BTN < NUM_BTN` and `btn_press[RST_BTN]`, go to `HOLD` with `hcnt ← 0`.
  - A `btn_press[RST_BTN]` while already in `HOLD` restarts the hold: `hcnt ← 0`.
- `sys_rstn` is a registered output. It is a decoded function of the state register, with no combinational path from any input.

## Timing
- **Reset** (`rstn` low at a rising edge):
  - All synchroniser flops, `cnt`, `level`, `rise`, and `hcnt` clear to 0.
  - FSM enters `HOLD`.
  - `btn_level = 0`, `btn_press = 0`, `sw_level = 0`, `sys_rstn = 0`.
- `rstn` asserted mid-debounce or mid-hold discards all progress. Counting starts afresh after release.
- **Debounce latency:** a raw change stable from edge t and meeting setup appears at `s2` after edge t+1. `level` flips after edge t+1+`DEBOUNCE_CYCLES`. The matching `btn_press` pulse is high for exactly that one cycle.
- **Reset release:** with `rstn` first sampled high at edge r, `sys_rstn` rises after edge r+`RST_HOLD_CYCLES-1`. It is low for exactly `RST_HOLD_CYCLES` cycles counted from the first `rstn`-high edge.
- **Button-triggered reset:** a `btn_press[RST_BTN]` pulse sampled in `RUN` at edge p drops `sys_rstn` after edge p. `sys_rstn` stays low `RST_HOLD_CYCLES` cycles.
- A continuously held reset button produces one press, so exactly one hold. Release and re-press are needed for another.
- Each channel holds at most one pending transition; there is no queuing.

## Structure
- Package `input_cond_pkg`:
  - FSM state enum `rst_state_t {HOLD, RUN}`.
  - Function `cnt_width(n)` wrapping `$clog2` with a floor of 1.
- Sub-module `debounce_ch` (parameter `DEBOUNCE_CYCLES`; ports `clk`, `rstn`, `raw`, `level`, `rise`).
  - Instantiated `NUM_BTN + NUM_SW` times via generate.
- The sequencer FSM is coded inline in `input_conditioner`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`, `RST_HOLD_CYCLES=8`, `NUM_BTN=4`, `NUM_SW=16`, `RST_BTN=0`.

1. **Power-up:** `rstn` low 5 cycles, then high → all outputs 0 during reset; `sys_rstn` rises after the 8th `rstn`-high edge and stays 1.
2. **Clean press:** `btn_raw[2]` 0→1 held 20 cycles → `btn_level[2]` rises 5 edges after the change; `btn_press[2]` is high for exactly that one cycle; other bits stay 0.
3. **Bounce:** `btn_raw[1]` toggled `1,0,1,0,1` at 2-cycle intervals, then held 1 → no `btn_press` during the bounce; one press 5 edges after the final stable edge.
4. **Switch pattern:** `sw_raw` 0→16'hA5C3 → `sw_level == 16'hA5C3` after 5 edges; a 3-cycle 16'h0000 glitch afterwards leaves `sw_level` unchanged.
5. **Button reset:** in `RUN`, debounced press of `btn_raw[0]` → `sys_rstn` low for exactly 8 cycles, then 1. A second press during the hold extends the low time to 8 cycles from that press.
6. **Reset mid-operation:** `rstn` pulsed low for 1 cycle while `cnt` is at 2 and `sys_rstn` is 1 → `btn_level` stays 0, and the debounce restarts needing a full 4 stable cycles. `sys_rstn` goes low and re-releases after 8 cycles.
